hub75_bcm_sched: RTL and testbench
==================================

HUB75_BCM_SCHED -- requirements
Module: hub75_bcm_sched

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning columns shifted per row; a power of two.
REQ-002 SHALL have parameter ROW_BITS, default 5, meaning row address width (32 scan rows, upper and lower halves in parallel).
REQ-003 SHALL have parameter PLANES, default 8, meaning BCM bit-planes per colour channel.
REQ-004 SHALL have parameter ON_BASE, default 16, meaning LED on-time in cycles for plane 0.
REQ-005 SHALL have parameter GHOST_CYC, default 4, meaning settle cycles after a row change (used only with the configuration macro).
REQ-006 SHALL have port clk, in, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, in, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port enable, in, 1 bit: run request.
REQ-009 SHALL have port rd_en, out, 1 bit: pixel read strobe to the pixel source.
REQ-010 SHALL have port rd_addr, out, ROW_BITS+log2(COLS) bits, ordered {row, col}.
REQ-011 SHALL have port rd_data, in, 48 bits, ordered {r1,g1,b1,r0,g0,b0} (8 bits each), valid exactly 1 cycle after rd_en.
REQ-012 SHALL have ports rgb0 and rgb1, out, 3 bits each, ordered {B,G,R}.
REQ-013 SHALL have port sclk_en, out, 1 bit: panel shift-clock qualifier.
REQ-014 SHALL have ports latch, out, 1 bit; blank, out, 1 bit, high = LEDs off; addry, out, ROW_BITS bits, the displayed row.
REQ-015 SHALL have port frame_start, out, 1 bit: one-cycle pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> SHIFT -> HOLD -> LATCH -> SHIFT, plus GHOST between LATCH and SHIFT when REQ-028 applies.
REQ-017 IDLE SHALL go to SHIFT on the first cycle with enable=1.
REQ-018 SHIFT SHALL assert rd_en for COLS consecutive cycles, with col 0..COLS-1 and row = shift_row.
REQ-019 The cycle after each rd_en SHALL present sclk_en=1, rgb0 = bit shift_plane of {b0,g0,r0}, and rgb1 = bit shift_plane of {b1,g1,r1}; otherwise sclk_en=0 and rgb0=rgb1=0.
REQ-020 After the last sclk_en, SHALL enter HOLD and stay there until on_cnt==0.
REQ-021 LATCH SHALL last 1 cycle with latch=1, blank=1, and in that same cycle: addry<=shift_row; on_cnt<=ON_BASE<<shift_plane.
REQ-022 LATCH SHALL also advance the shift position: plane+1; at PLANES-1, plane wraps to 0 and row+1; on row wrap from 2^ROW_BITS-1 to 0, frame_start=1 for that cycle.
REQ-023 on_cnt SHALL decrement by 1 per cycle while nonzero; blank SHALL be 1 whenever on_cnt==0, in LATCH, or in GHOST.
REQ-024 on_cnt SHALL be wide enough for ON_BASE<<(PLANES-1) without overflow.
REQ-025 Shifting the next plane SHALL overlap display of the current plane; if shifting ends first, HOLD absorbs the difference; if on_cnt expires first, blank=1 until LATCH.
REQ-026 enable SHALL be sampled only at the exit of LATCH (or GHOST when present): if 0, go to IDLE, let the loaded on_cnt drain, then hold blank=1.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE; shift row/plane=0; on_cnt=0; blank=1; all other outputs 0. This SHALL apply equally mid-SHIFT or mid-display.

Configuration
REQ-028 With HUB75_GHOST_BLANK_EN defined, LATCH SHALL go to GHOST, which holds blank=1 and freezes on_cnt for GHOST_CYC cycles before SHIFT.
REQ-029 Without HUB75_GHOST_BLANK_EN, LATCH SHALL go directly to SHIFT, and on_cnt SHALL start decrementing the cycle after LATCH.

Structure
REQ-030 A shared package hub75_pkg SHALL hold the FSM state enum, the rd_data field offsets, and the default parameter constants.
REQ-031 One sub-module, hub75_oncnt, SHALL contain the on-time down-counter (load value, expiry flag).

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles, then release with enable=0 -> blank=1, all other outputs 0, rd_en never asserted.
REQ-033 First row: enable=1, rd_data={48{col-dependent}} -> exactly 64 rd_en with addr 0..63, each followed 1 cycle later by sclk_en and correct plane-0 bits.
REQ-034 Plane timing: at the plane-0 latch -> blank=0 for exactly 16 cycles; at the plane-7 latch -> blank=0 for exactly 2048 cycles.
REQ-035 Wrap: run through row 31, plane 7 -> frame_start is a single pulse; the next rd_addr row is 0; addry follows 0..31 in order.
REQ-036 Enable drop: enable=0 mid-SHIFT -> the current row-plane completes and latches, the state returns to IDLE after LATCH, and blank=1 after the drain.
REQ-037 Ghost: with HUB75_GHOST_BLANK_EN -> exactly 4 extra blank cycles follow every latch before the first sclk_en; without it -> 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 bit-plane (BCM) scan scheduler.
package hub75_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StHold,
    StLatch,
    StGhost
  } state_e;

  localparam int unsigned COLS_DEF      = 64;
  localparam int unsigned ROW_BITS_DEF  = 5;
  localparam int unsigned PLANES_DEF    = 8;
  localparam int unsigned ON_BASE_DEF   = 16;
  localparam int unsigned GHOST_CYC_DEF = 4;

  // rd_data = {r1, g1, b1, r0, g0, b0}
  localparam int unsigned B0_LSB = 0;
  localparam int unsigned G0_LSB = 8;
  localparam int unsigned R0_LSB = 16;
  localparam int unsigned B1_LSB = 24;
  localparam int unsigned G1_LSB = 32;
  localparam int unsigned R1_LSB = 40;

  localparam int unsigned ONCNT_W_DEF = $clog2((ON_BASE_DEF << (PLANES_DEF - 1)) + 1);

endpackage

// File: rtl/hub75_oncnt.sv
// LED on-time down-counter: loads a plane's on-time, counts to zero, can be frozen.
module hub75_oncnt
  import hub75_pkg::*;
#(
  parameter int unsigned CNT_W = ONCNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hub75_bcm_sched.sv
// HUB75 panel scheduler: shifts one row-plane while the previous one is displayed.
// Define HUB75_GHOST_BLANK_EN to insert GHOST_CYC blanked settle cycles after each latch.
module hub75_bcm_sched
  import hub75_pkg::*;
#(
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned ROW_BITS  = ROW_BITS_DEF,
  parameter int unsigned PLANES    = PLANES_DEF,
  parameter int unsigned ON_BASE   = ON_BASE_DEF,
  parameter int unsigned GHOST_CYC = GHOST_CYC_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  output logic                               rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]   rd_addr,
  input  logic [47:0]                        rd_data,
  output logic [2:0]                         rgb0,
  output logic [2:0]                         rgb1,
  output logic                               sclk_en,
  output logic                               latch,
  output logic                               blank,
  output logic [ROW_BITS-1:0]                addry,
  output logic                               frame_start
);

  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned CNT_W   = $clog2((ON_BASE << (PLANES - 1)) + 1);
  localparam int unsigned GHOST_W = $clog2(GHOST_CYC + 1);

  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = {ROW_BITS{1'b1}};
  localparam logic [GHOST_W-1:0]  GHOST_LAST = GHOST_W'(GHOST_CYC - 1);

  state_e               r_state, w_state_d;
  logic [COL_W-1:0]     r_col;
  logic                 r_cols_done;
  logic [ROW_BITS-1:0]  r_row;
  logic [PLANE_W-1:0]   r_plane;
  logic                 r_sclk_en;
  logic [ROW_BITS-1:0]  r_addry;
  logic [GHOST_W-1:0]   r_ghost_cnt;

  logic                 w_rd_en;
  logic                 w_latch;
  logic                 w_ghost;
  logic                 w_on_zero;
  logic [CNT_W-1:0]     w_load_val;
  logic [7:0]           w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;

  always_comb begin
    w_state_d = r_state;
    w_rd_en   = 1'b0;
    w_latch   = 1'b0;
    w_ghost   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_d = StShift;
      end
      // Last SHIFT cycle only carries the final sclk_en; no read is issued.
      StShift: begin
        w_rd_en = !r_cols_done;
        if (r_cols_done) w_state_d = StHold;
      end
      StHold: begin
        if (w_on_zero) w_state_d = StLatch;
      end
      StLatch: begin
        w_latch = 1'b1;
`ifdef HUB75_GHOST_BLANK_EN
        w_state_d = StGhost;
`else
        w_state_d = enable ? StShift : StIdle;
`endif
      end
      StGhost: begin
        w_ghost = 1'b1;
        if (r_ghost_cnt == GHOST_LAST) w_state_d = enable ? StShift : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_col       <= '0;
      r_cols_done <= 1'b0;
      r_row       <= '0;
      r_plane     <= '0;
      r_sclk_en   <= 1'b0;
      r_addry     <= '0;
      r_ghost_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sclk_en   <= w_rd_en;
      r_ghost_cnt <= w_ghost ? r_ghost_cnt + 1'b1 : '0;
      // Column wraps naturally back to 0 since COLS is a power of two.
      if (w_rd_en) begin
        r_col <= r_col + 1'b1;
        if (r_col == COL_LAST) r_cols_done <= 1'b1;
      end
      if (w_latch) begin
        r_cols_done <= 1'b0;
        r_addry     <= r_row;
        if (r_plane == PLANE_LAST) begin
          r_plane <= '0;
          r_row   <= r_row + 1'b1;
        end else begin
          r_plane <= r_plane + 1'b1;
        end
      end
    end
  end

  assign w_load_val = CNT_W'(ON_BASE) << r_plane;

  hub75_oncnt #(
    .CNT_W (CNT_W)
  ) u_oncnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_latch),
    .i_load_val (w_load_val),
    .i_hold     (w_ghost),
    .o_zero     (w_on_zero)
  );

  assign w_b0 = rd_data[B0_LSB +: 8];
  assign w_g0 = rd_data[G0_LSB +: 8];
  assign w_r0 = rd_data[R0_LSB +: 8];
  assign w_b1 = rd_data[B1_LSB +: 8];
  assign w_g1 = rd_data[G1_LSB +: 8];
  assign w_r1 = rd_data[R1_LSB +: 8];

  assign rd_en       = w_rd_en;
  assign rd_addr     = {r_row, r_col};
  assign sclk_en     = r_sclk_en;
  assign rgb0        = r_sclk_en ? {w_b0[r_plane], w_g0[r_plane], w_r0[r_plane]} : 3'b000;
  assign rgb1        = r_sclk_en ? {w_b1[r_plane], w_g1[r_plane], w_r1[r_plane]} : 3'b000;
  assign latch       = w_latch;
  assign blank       = w_on_zero | w_latch | w_ghost;
  assign addry       = r_addry;
  assign frame_start = w_latch && (r_plane == PLANE_LAST) && (r_row == ROW_LAST);

endmodule

// File: tb/tb_hub75_bcm_sched.sv
// Directed bench: default-size scheduler for row/plane timing, small instance for frame wrap.
`timescale 1ns/1ps
module tb_hub75_bcm_sched;

`ifdef HUB75_GHOST_BLANK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        en_w = 1'b0;

  logic        rd_en, sclk_en, latch, blank, frame_start;
  logic [10:0] rd_addr;
  logic [47:0] rd_data;
  logic [2:0]  rgb0, rgb1;
  logic [4:0]  addry;

  logic        rd_en_w, sclk_en_w, latch_w, blank_w, frame_start_w;
  logic [6:0]  rd_addr_w;
  logic [47:0] rd_data_w;
  logic [2:0]  rgb0_w, rgb1_w;
  logic [4:0]  addry_w;

  always #5 clk = ~clk;

  hub75_bcm_sched #(
    .COLS(64), .ROW_BITS(5), .PLANES(8), .ON_BASE(16), .GHOST_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rgb0(rgb0), .rgb1(rgb1), .sclk_en(sclk_en), .latch(latch),
    .blank(blank), .addry(addry), .frame_start(frame_start)
  );

  hub75_bcm_sched #(
    .COLS(4), .ROW_BITS(5), .PLANES(8), .ON_BASE(1), .GHOST_CYC(4)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(en_w), .rd_en(rd_en_w), .rd_addr(rd_addr_w),
    .rd_data(rd_data_w), .rgb0(rgb0_w), .rgb1(rgb1_w), .sclk_en(sclk_en_w), .latch(latch_w),
    .blank(blank_w), .addry(addry_w), .frame_start(frame_start_w)
  );

  // Pixel source: fields {r1,g1,b1,r0,g0,b0}, one-cycle read latency.
  function automatic logic [47:0] pix(input logic [5:0] col);
    logic [7:0] c;
    c = {2'b00, col};
    return {c ^ 8'hA5, c + 8'd7, ~c, c * 8'd3, c ^ 8'h3C, c};
  endfunction

  always @(posedge clk) rd_data <= rd_en ? pix(rd_addr[5:0]) : 48'h0;
  assign rd_data_w = 48'h0;

  function automatic logic [2:0] exp_rgb(input int col, input int p, input bit hi);
    logic [7:0] c, r, g, b;
    c = 8'(col);
    if (hi) begin
      r = c ^ 8'hA5; g = c + 8'd7; b = ~c;
    end else begin
      r = c * 8'd3;  g = c ^ 8'h3C; b = c;
    end
    return {b[p], g[p], r[p]};
  endfunction

  task automatic wait_latch(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (latch === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL latch_timeout: no latch within %0d cycles", budget);
    end
  endtask

  // Call at a latch negedge: counts blanked cycles, then lit cycles.
  task automatic measure_on(output int gap, output int on);
    gap = 0;
    on  = 0;
    @(negedge clk);
    while (blank === 1'b1 && gap < 50) begin gap++; @(negedge clk); end
    while (blank === 1'b0 && on < 5000) begin on++; @(negedge clk); end
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0; en = 1'b0; en_w = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (blank !== 1'b1) begin bad++; $display("FAIL rst_blank: got %b want 1", blank); end
    total++;
    if ({rd_en, sclk_en, latch, frame_start} !== 4'b0) begin
      bad++; $display("FAIL rst_strobes: got %b want 0000", {rd_en, sclk_en, latch, frame_start});
    end
    total++;
    if ({rgb0, rgb1} !== 6'b0) begin bad++; $display("FAIL rst_rgb: got %b want 0", {rgb0, rgb1}); end
    total++;
    if (addry !== 5'd0 || rd_addr !== 11'd0) begin
      bad++; $display("FAIL rst_addr: got addry=%0d rd_addr=%0d want 0", addry, rd_addr);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || blank !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL idle_quiet: got activity want rd_en=0 blank=1"); end
  endtask

  task automatic test_first_row();
    int nrd, nsc, prev_col;
    bit prev_rd;
    nrd = 0; nsc = 0; prev_col = 0; prev_rd = 1'b0;
    en = 1'b1;
    for (int n = 0; n < 66; n++) begin
      @(negedge clk);
      total++;
      if (sclk_en !== prev_rd) begin
        bad++; $display("FAIL sclk_follow: n=%0d got %b want %b", n, sclk_en, prev_rd);
      end
      if (sclk_en === 1'b1) begin
        nsc++;
        total++;
        if (rgb0 !== exp_rgb(prev_col, 0, 1'b0) || rgb1 !== exp_rgb(prev_col, 0, 1'b1)) begin
          bad++;
          $display("FAIL rgb_plane0: col=%0d got %b/%b want %b/%b", prev_col, rgb0, rgb1,
                   exp_rgb(prev_col, 0, 1'b0), exp_rgb(prev_col, 0, 1'b1));
        end
      end else begin
        total++;
        if ({rgb0, rgb1} !== 6'b0) begin bad++; $display("FAIL rgb_idle: got %b want 0", {rgb0, rgb1}); end
      end
      prev_rd = (rd_en === 1'b1);
      if (rd_en === 1'b1) begin
        total++;
        if (rd_addr !== {5'd0, 6'(nrd)}) begin
          bad++; $display("FAIL rd_addr_row0: got %0d want %0d", rd_addr, nrd);
        end
        prev_col = nrd;
        nrd++;
      end
    end
    total++;
    if (nrd != 64) begin bad++; $display("FAIL rd_count: got %0d want 64", nrd); end
    total++;
    if (nsc != 64) begin bad++; $display("FAIL sclk_count: got %0d want 64", nsc); end
  endtask

  task automatic test_plane_timing();
    bit ok;
    int gap, on;
    wait_latch(200, ok);
    total++;
    if (blank !== 1'b1) begin bad++; $display("FAIL latch_blank: got %b want 1", blank); end
    measure_on(gap, on);
    total++;
    if (gap != GAP) begin bad++; $display("FAIL ghost_gap_p0: got %0d want %0d", gap, GAP); end
    total++;
    if (on != 16) begin bad++; $display("FAIL on_plane0: got %0d want 16", on); end
    for (int k = 1; k < 8; k++) wait_latch(3000, ok);
    measure_on(gap, on);
    total++;
    if (gap != GAP) begin bad++; $display("FAIL ghost_gap_p7: got %0d want %0d", gap, GAP); end
    total++;
    if (on != 2048) begin bad++; $display("FAIL on_plane7: got %0d want 2048", on); end
  endtask

  task automatic test_enable_drop();
    bit ok, seen;
    int nrd, gap, on, i;
    wait_latch(3000, ok);  // row 1 plane 0; the following shift is row 1 plane 1
    i = 0;
    while (rd_en !== 1'b1 && i < 100) begin @(negedge clk); i++; end
    total++;
    if (rd_addr !== {5'd1, 6'd0}) begin bad++; $display("FAIL row1_start: got %0d want 64", rd_addr); end
    nrd = 1;
    while (nrd < 10) begin @(negedge clk); if (rd_en === 1'b1) nrd++; end
    en = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (rd_en === 1'b1) nrd++;
      if (latch === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL drop_latch: got no latch want latch"); end
    total++;
    if (nrd != 64) begin bad++; $display("FAIL drop_row_complete: got %0d want 64", nrd); end
    measure_on(gap, on);
    total++;
    if (gap != GAP || on != 32) begin
      bad++; $display("FAIL drop_drain: got gap=%0d on=%0d want gap=%0d on=32", gap, on, GAP);
    end
    seen = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || blank !== 1'b1 || latch !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL drop_idle: got activity want idle and blank"); end
  endtask

  task automatic test_wrap();
    int k, frames;
    bit exp_fs;
    k = 0; frames = 0;
    en_w = 1'b1;
    for (int c = 0; c < 40000 && k < 256; c++) begin
      @(negedge clk);
      if (frame_start_w === 1'b1) begin
        frames++;
        total++;
        if (latch_w !== 1'b1) begin bad++; $display("FAIL fs_outside_latch: got latch=%b want 1", latch_w); end
      end
      if (sclk_en_w === 1'b1) begin
        total++;
        if ({rgb0_w, rgb1_w} !== 6'b0) begin bad++; $display("FAIL wrap_rgb: got %b want 0", {rgb0_w, rgb1_w}); end
      end
      if (latch_w === 1'b1) begin
        exp_fs = (k == 255);
        total++;
        if (frame_start_w !== exp_fs) begin
          bad++; $display("FAIL frame_start: k=%0d got %b want %b", k, frame_start_w, exp_fs);
        end
        @(negedge clk);
        total++;
        if (addry_w !== 5'(k / 8)) begin bad++; $display("FAIL addry_seq: got %0d want %0d", addry_w, k / 8); end
        total++;
        if (frame_start_w !== 1'b0) begin bad++; $display("FAIL fs_width: got 1 want 0"); end
        total++;
        if (blank_w !== (GAP > 0)) begin
          bad++; $display("FAIL post_latch_blank: got %b want %b", blank_w, GAP > 0);
        end
        k++;
      end
    end
    total++;
    if (k != 256) begin bad++; $display("FAIL wrap_latches: got %0d want 256", k); end
    total++;
    if (frames != 1) begin bad++; $display("FAIL frame_pulses: got %0d want 1", frames); end
    for (int i = 0; i < 50 && rd_en_w !== 1'b1; i++) @(negedge clk);
    total++;
    if (rd_en_w !== 1'b1 || rd_addr_w !== 7'd0) begin
      bad++; $display("FAIL wrap_next_addr: got en=%b addr=%0d want en=1 addr=0", rd_en_w, rd_addr_w);
    end
    en_w = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    en = 1'b1;
    wait_latch(400, ok);
    repeat (6) @(negedge clk);
    total++;
    if (blank !== 1'b0) begin bad++; $display("FAIL pre_reset_lit: got %b want 0", blank); end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_en, sclk_en, latch, blank} !== 4'b0001) begin
      bad++; $display("FAIL mid_reset_out: got %b want 0001", {rd_en, sclk_en, latch, blank});
    end
    total++;
    if (addry !== 5'd0) begin bad++; $display("FAIL mid_reset_addry: got %0d want 0", addry); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rd_en !== 1'b1 || rd_addr !== 11'd0) begin
      bad++; $display("FAIL restart_addr: got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_plane_timing();
    test_enable_drop();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
